// File: rtl/data_memory_block_if.sv
// Block-transfer handshake between the data cache (master) and the multi-cycle data memory (slave).
interface data_memory_block_if #(
  parameter int ADDR_WIDTH  = 6,
  parameter int BLOCK_BYTES = 4
);
  logic                     read;
  logic                     write;
  logic [ADDR_WIDTH-1:0]    address;
  logic [8*BLOCK_BYTES-1:0] writedata;
  logic [8*BLOCK_BYTES-1:0] readdata;
  logic                     busywait;
  logic                     conflict;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait, conflict
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait, conflict
  );
endinterface

// File: rtl/data_memory_block.sv
// Multi-cycle block memory (IDLE/BUSY/DONE) serving whole cache blocks per access.
// Optional DMEM_ACCESS_COUNT_EN adds saturating read_count/write_count outputs.
module data_memory_block #(
  parameter int ADDR_WIDTH  = 6,
  parameter int BLOCK_BYTES = 4,
  parameter int LATENCY     = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  data_memory_block_if.slave  bus
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]         read_count,
  output logic [15:0]         write_count
`endif
);

  localparam int DATA_W = 8 * BLOCK_BYTES;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int CNT_W  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        counter_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_W-1:0]       wdata_reg;
  logic                    is_write_reg;
  logic [DATA_W-1:0]       readdata_reg;
  logic                    conflict_reg;
  logic [DATA_W-1:0]       mem_reg [DEPTH];

  wire completion = (state_reg == BUSY) && (counter_reg == '0);

  // Memory contents are part of the reset domain, so the array is a register file.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      counter_reg  <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      is_write_reg <= 1'b0;
      readdata_reg <= '0;
      conflict_reg <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      conflict_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.read ^ bus.write) begin
            addr_reg     <= bus.address;
            is_write_reg <= bus.write;
            if (bus.write) begin
              wdata_reg <= bus.writedata;
            end
            counter_reg <= CNT_W'(LATENCY - 1);
            state_reg   <= BUSY;
          end else if (bus.read && bus.write) begin
            conflict_reg <= 1'b1;
          end
        end
        BUSY: begin
          if (counter_reg == '0) begin
            if (is_write_reg) begin
              mem_reg[addr_reg] <= wdata_reg;
            end else begin
              readdata_reg <= mem_reg[addr_reg];
            end
            state_reg <= DONE;
          end else begin
            counter_reg <= counter_reg - CNT_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.readdata = readdata_reg;
  assign bus.conflict = conflict_reg;
  assign bus.busywait = ((state_reg == IDLE) && (bus.read || bus.write)) || (state_reg == BUSY);

`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] read_count_reg;
  logic [15:0] write_count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_count_reg  <= '0;
      write_count_reg <= '0;
    end else if (completion) begin
      if (is_write_reg) begin
        if (write_count_reg != 16'hFFFF) write_count_reg <= write_count_reg + 16'd1;
      end else begin
        if (read_count_reg != 16'hFFFF) read_count_reg <= read_count_reg + 16'd1;
      end
    end
  end

  assign read_count  = read_count_reg;
  assign write_count = write_count_reg;
`else
  wire unused_completion = completion;
`endif

endmodule
